// File: rtl/irq_sequencer_if.sv
// Bundle between the interrupt sequencer and the CPU front end: the sources and
// pipeline status going in, the flush/redirect/acknowledge outputs coming back.
interface irq_sequencer_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irq_req;
  logic               interrupt_mask;
  logic               stall;
  logic [31:0]        epc_candidate;
  logic               rti;
  logic               flush;
  logic               pc_override_valid;
  logic [31:0]        pc_override;
  logic [NUM_SRC-1:0] irq_ack;
  logic               in_service;
  logic [31:0]        epc;

  modport master (
    output irq_req, interrupt_mask, stall, epc_candidate, rti,
    input  flush, pc_override_valid, pc_override, irq_ack, in_service, epc
  );

  modport slave (
    input  irq_req, interrupt_mask, stall, epc_candidate, rti,
    output flush, pc_override_valid, pc_override, irq_ack, in_service, epc
  );
endinterface

// File: rtl/irq_sequencer.sv
// Interrupt entry/exit sequencer: arbitrate, drain, vector, service, return.
// Define IRQ_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module irq_sequencer #(
  parameter int          NUM_SRC      = 4,
  parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
  parameter int          VEC_STRIDE   = 16,
  parameter int          DRAIN_CYCLES = 3
) (
  input logic            clk,
  input logic            rst_n,
  irq_sequencer_if.slave bus
);
  localparam int         ID_W     = $clog2(NUM_SRC);
  localparam logic [2:0] CNT_LAST = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_VECTOR, S_SERVICE, S_RETURN} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [ID_W-1:0] id_reg, id_next;
  logic [31:0]     epc_reg, epc_next;
  logic            ack_pend_reg, ack_pend_next;
  logic [ID_W-1:0] winner;
  logic [31:0]     vec_addr;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_reg, ptr_next;

  // Walk downward so the lowest offset from the pointer is assigned last and wins.
  always_comb begin
    winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (bus.irq_req[(int'(ptr_reg) + k) % NUM_SRC])
        winner = ID_W'((int'(ptr_reg) + k) % NUM_SRC);
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (state_reg == S_IDLE && state_next == S_DRAIN)
      ptr_next = (winner == ID_W'(NUM_SRC - 1)) ? '0 : winner + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end
`else
  always_comb begin
    winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (bus.irq_req[k]) winner = ID_W'(k);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      id_reg       <= '0;
      epc_reg      <= '0;
      ack_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      id_reg       <= id_next;
      epc_reg      <= epc_next;
      ack_pend_reg <= ack_pend_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    id_next       = id_reg;
    epc_next      = epc_reg;
    ack_pend_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if ((|bus.irq_req) && !bus.interrupt_mask && !bus.stall) begin
          state_next    = S_DRAIN;
          id_next       = winner;
          epc_next      = bus.epc_candidate;
          cnt_next      = '0;
          ack_pend_next = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!bus.stall) begin
          if (cnt_reg == CNT_LAST) state_next = S_VECTOR;
          else                     cnt_next   = cnt_reg + 3'd1;
        end
      end
      S_VECTOR:  if (!bus.stall) state_next = S_SERVICE;
      S_SERVICE: if (bus.rti)    state_next = S_RETURN;
      S_RETURN:  if (!bus.stall) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign vec_addr = VEC_BASE + 32'(id_reg) * 32'(VEC_STRIDE);

  always_comb begin
    bus.flush             = 1'b0;
    bus.pc_override_valid = 1'b0;
    bus.pc_override       = '0;
    bus.in_service        = (state_reg != S_IDLE);
    case (state_reg)
      S_DRAIN:  bus.flush = 1'b1;
      S_VECTOR: begin
        bus.pc_override_valid = 1'b1;
        bus.pc_override       = vec_addr;
      end
      S_RETURN: begin
        bus.flush             = 1'b1;
        bus.pc_override_valid = 1'b1;
        bus.pc_override       = epc_reg;
      end
      default: ;
    endcase
  end

  assign bus.epc = epc_reg;

  // The acknowledge flag lives exactly one cycle, so a stalled first DRAIN cycle does not repeat it.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ack
      assign bus.irq_ack[gi] = ack_pend_reg && (state_reg == S_DRAIN) && (id_reg == ID_W'(gi));
    end
  endgenerate
endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a phase-level reference model.
module tb_irq_sequencer;
  localparam int          N      = 4;
  localparam logic [31:0] VBASE  = 32'h0000_0100;
  localparam int          STRIDE = 16;
  localparam int          DRAIN  = 3;

  localparam int P_IDLE = 0, P_DRAIN = 1, P_VECTOR = 2, P_SERVICE = 3, P_RETURN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_sequencer_if #(.NUM_SRC(N)) bus();

  irq_sequencer #(
    .NUM_SRC(N), .VEC_BASE(VBASE), .VEC_STRIDE(STRIDE), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus "drain cycles still owed" and "cycles since acceptance".
  int          m_phase = P_IDLE;
  int          m_left  = 0;
  int          m_age   = 99;
  int          m_id    = 0;
  int          m_ptr   = 0;
  logic [31:0] m_epc   = '0;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
`ifdef IRQ_ROUND_ROBIN_EN
      int idx = (ptr + k) % N;
`else
      int idx = k + 0 * ptr;
`endif
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_left = 0; m_age = 99; m_id = 0; m_ptr = 0; m_epc = '0;
    end else begin
      if (m_age < 99) m_age++;
      case (m_phase)
        P_IDLE: if (bus.irq_req != '0 && !bus.interrupt_mask && !bus.stall) begin
          m_id    = pick(bus.irq_req, m_ptr);
          m_ptr   = (m_id + 1) % N;
          m_epc   = bus.epc_candidate;
          m_left  = DRAIN;
          m_age   = 0;
          m_phase = P_DRAIN;
          txn++;
          $display("txn %0d: accept src %0d req %b epc %h at %0t", txn, m_id, bus.irq_req, m_epc, $time);
        end
        P_DRAIN: if (!bus.stall) begin
          m_left--;
          if (m_left == 0) m_phase = P_VECTOR;
        end
        P_VECTOR:  if (!bus.stall) m_phase = P_SERVICE;
        P_SERVICE: if (bus.rti)    m_phase = P_RETURN;
        P_RETURN:  if (!bus.stall) m_phase = P_IDLE;
        default:   m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_ack;
    logic [31:0]  e_pc;
    e_ack = '0;
    if (m_phase == P_DRAIN && m_age == 0) e_ack[m_id] = 1'b1;
    e_pc = (m_phase == P_VECTOR) ? VBASE + 32'(m_id * STRIDE) :
           (m_phase == P_RETURN) ? m_epc : 32'h0;
    check("m_flush", 32'(bus.flush), 32'(m_phase == P_DRAIN || m_phase == P_RETURN));
    check("m_pov", 32'(bus.pc_override_valid), 32'(m_phase == P_VECTOR || m_phase == P_RETURN));
    check("m_pc", bus.pc_override, e_pc);
    check("m_ack", 32'(bus.irq_ack), 32'(e_ack));
    check("m_in_service", 32'(bus.in_service), 32'(m_phase != P_IDLE));
    check("m_epc", bus.epc, m_epc);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_service();
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_service && !bus.flush && !bus.pc_override_valid;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_service: got no SERVICE expected SERVICE within 20 cycles at %0t", $time);
    end
  endtask

  // Called at a negedge in SERVICE; returns at the negedge of the following IDLE cycle.
  task automatic do_return(input logic [31:0] exp_epc);
    step(); bus.rti = 1'b1;
    step(); bus.rti = 1'b0;
    @(negedge clk);
    check("ret_flush", 32'(bus.flush), 32'd1);
    check("ret_pov", 32'(bus.pc_override_valid), 32'd1);
    check("ret_pc", bus.pc_override, exp_epc);
    step();
    @(negedge clk);
    check("ret_idle", 32'(bus.in_service), 32'd0);
  endtask

  initial begin
    int nf;
    int np;
    logic [N-1:0] got;
    logic [N-1:0] exp_acks [3];
`ifdef IRQ_ROUND_ROBIN_EN
    exp_acks = '{4'b0001, 4'b0010, 4'b1000};
`else
    exp_acks = '{4'b0001, 4'b0001, 4'b0001};
`endif
    bus.irq_req = '0; bus.interrupt_mask = 1'b0; bus.stall = 1'b0;
    bus.epc_candidate = '0; bus.rti = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_pov", 32'(bus.pc_override_valid), 32'd0);
    check("rst_pc", bus.pc_override, 32'h0);
    check("rst_ack", 32'(bus.irq_ack), 32'd0);
    check("rst_in_service", 32'(bus.in_service), 32'd0);
    check("rst_epc", bus.epc, 32'h0);
    #1 rst_n = 1'b1;

    // Single request, no stall
    step(); bus.irq_req = 4'b0100; bus.epc_candidate = 32'h0000_2000;
    step(); bus.irq_req = '0; bus.epc_candidate = 32'hdead_beef;
    @(negedge clk);
    check("a_flush1", 32'(bus.flush), 32'd1);
    check("a_ack1", 32'(bus.irq_ack), 32'b0100);
    @(negedge clk);
    check("a_flush2", 32'(bus.flush), 32'd1);
    check("a_ack2", 32'(bus.irq_ack), 32'd0);
    @(negedge clk);
    check("a_flush3", 32'(bus.flush), 32'd1);
    check("a_pov3", 32'(bus.pc_override_valid), 32'd0);
    @(negedge clk);
    check("a_flush4", 32'(bus.flush), 32'd0);
    check("a_pov4", 32'(bus.pc_override_valid), 32'd1);
    check("a_pc4", bus.pc_override, 32'h0000_0120);
    @(negedge clk);
    check("a_pov5", 32'(bus.pc_override_valid), 32'd0);
    check("a_in_service5", 32'(bus.in_service), 32'd1);
    check("a_epc", bus.epc, 32'h0000_2000);
    do_return(32'h0000_2000);

    // rti in IDLE is ignored
    step(); bus.rti = 1'b1;
    step(); step(); bus.rti = 1'b0;
    @(negedge clk);
    check("rti_idle_svc", 32'(bus.in_service), 32'd0);
    check("rti_idle_flush", 32'(bus.flush), 32'd0);

    // Stall two cycles mid-DRAIN and one cycle in VECTOR
    step(); bus.irq_req = 4'b0001; bus.epc_candidate = 32'h0000_3000;
    nf = 0; np = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) bus.irq_req = '0;
      bus.stall = (k == 2 || k == 3 || k == 6);
      @(negedge clk);
      if (bus.flush) nf++;
      if (bus.pc_override_valid) begin
        np++;
        check("b_pc", bus.pc_override, 32'h0000_0100);
      end
    end
    bus.stall = 1'b0;
    check("b_flush_len", 32'(nf), 32'd5);
    check("b_pov_len", 32'(np), 32'd2);
    do_return(32'h0000_3000);

    // Mask, then no nesting while in SERVICE
    step(); bus.interrupt_mask = 1'b1; bus.irq_req = 4'b0001; bus.epc_candidate = 32'h0000_4000;
    repeat (3) begin
      step();
      @(negedge clk);
      check("c_masked", 32'(bus.in_service), 32'd0);
    end
    step(); bus.interrupt_mask = 1'b0;
    @(negedge clk);
    check("c_unmask_same", 32'(bus.in_service), 32'd0);
    step(); bus.irq_req = 4'b0010;
    @(negedge clk);
    check("c_unmask_ack", 32'(bus.irq_ack), 32'b0001);
    wait_service();
    repeat (3) begin
      step(); bus.interrupt_mask = 1'b0;
      @(negedge clk);
      check("c_nonest_ack", 32'(bus.irq_ack), 32'd0);
      check("c_nonest_flush", 32'(bus.flush), 32'd0);
    end
    do_return(32'h0000_4000);
    @(negedge clk);
    check("c_reentry_ack", 32'(bus.irq_ack), 32'b0010);
    step(); bus.irq_req = '0;
    wait_service();
    do_return(32'h0000_4000);

    // Arbitration across three sequences with irq_req held
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; bus.irq_req = 4'b1011;
    for (int s = 0; s < 3; s++) begin
      got = '0;
      for (int k = 0; k < 10 && got == '0; k++) begin
        @(negedge clk);
        got = bus.irq_ack;
      end
      check("d_arb_ack", 32'(got), 32'(exp_acks[s]));
      wait_service();
      do_return(bus.epc);
    end

    // Reset during the second DRAIN cycle
    step(); bus.irq_req = '0; rst_n = 1'b0;
    step(); rst_n = 1'b1; bus.irq_req = 4'b0001; bus.epc_candidate = 32'h0000_5000;
    step(); bus.irq_req = '0;
    @(negedge clk);
    check("e_flush_pre", 32'(bus.flush), 32'd1);
    step(); rst_n = 1'b0;
    #1;
    check("e_flush", 32'(bus.flush), 32'd0);
    check("e_pov", 32'(bus.pc_override_valid), 32'd0);
    check("e_pc", bus.pc_override, 32'h0);
    check("e_ack", 32'(bus.irq_ack), 32'd0);
    check("e_in_service", 32'(bus.in_service), 32'd0);
    check("e_epc", bus.epc, 32'h0);
    step(); rst_n = 1'b1;

    // Randomized traffic; the per-cycle compare process does the checking
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = ($urandom_range(0, 999) != 0);
      bus.irq_req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      bus.interrupt_mask = ($urandom_range(0, 3) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.rti = ($urandom_range(0, 4) == 0);
      if (bus.rti) bus.stall = 1'b0;
      bus.epc_candidate = $urandom;
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1000000 at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
